// File: rtl/sdram_arb_pkg.sv
// Shared types and the slot priority decision for the SDRAM slot arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BOOT, CPU, DMA} owner_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [22:0] addr;
        logic [1:0]  bank;
        logic [7:0]  din;
    } req_t;

    localparam int unsigned SLOT_LEN = 16;

    function automatic owner_t arbitrate(input logic boot_mode, input logic boot_wr,
                                         input logic cpu_req, input logic dma_req,
                                         input logic starve_full);
        owner_t who;
        if (boot_mode)                 who = boot_wr ? BOOT : IDLE;
        else if (dma_req && starve_full) who = DMA;
        else if (cpu_req)              who = CPU;
        else if (dma_req)              who = DMA;
        else                           who = IDLE;
        return who;
    endfunction

endpackage

// File: rtl/sdram_slot_arbiter.sv
// Grants the single SDRAM command port to boot loader, CPU or DMA, one owner per
// clkref slot, and registers the selected command toward the sdram controller.
module sdram_slot_arbiter #(
    parameter int unsigned DATA_LAT = 8,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        boot_mode,
    input  logic        boot_wr,
    input  logic [22:0] boot_addr,
    input  logic [1:0]  boot_bank,
    input  logic [7:0]  boot_din,
    output logic        boot_ack,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [1:0]  cpu_bank,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wait,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [22:0] dma_addr,
    input  logic [1:0]  dma_bank,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [7:0]  dma_dout,
    output logic        sd_oe,
    output logic        sd_we,
    output logic [22:0] sd_addr,
    output logic [1:0]  sd_bank,
    output logic [7:0]  sd_din,
    input  logic [7:0]  sd_dout
);
    import sdram_arb_pkg::*;

    // Read data must land inside the slot, so no ack can straddle a ce_ref.
    if (DATA_LAT < 2 || DATA_LAT >= SLOT_LEN) begin : g_bad_data_lat
        $error("DATA_LAT must lie in [2, SLOT_LEN)");
    end
    if (MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must fit the 8-bit starve counter");
    end

    localparam logic [7:0] MaxStarve = 8'(MAX_WAIT);
    localparam logic [3:0] LastLat   = 4'(DATA_LAT - 1);
    localparam logic [3:0] PhaseMax  = 4'(SLOT_LEN - 1);

    owner_t      owner;
    owner_t      grant;
    logic [7:0]  starve;
    logic [3:0]  phase;
    logic        cpu_req;
    logic        starve_full;
    logic        forced;
    req_t        sel;

    always_comb begin
        cpu_req     = cpu_rd | cpu_wr;
        starve_full = (starve == MaxStarve);
        forced      = !boot_mode && dma_req && starve_full;
        grant       = arbitrate(boot_mode, boot_wr, cpu_req, dma_req, starve_full);
        // IDLE keeps the address/data lines parked on their last value.
        sel = '{rd: 1'b0, wr: 1'b0, addr: sd_addr, bank: sd_bank, din: sd_din};
        unique case (grant)
            BOOT: sel = '{rd: 1'b0, wr: 1'b1, addr: boot_addr, bank: boot_bank, din: boot_din};
            CPU:  sel = '{rd: cpu_rd, wr: cpu_wr, addr: cpu_addr, bank: cpu_bank, din: cpu_din};
            DMA:  sel = '{rd: !dma_we, wr: dma_we, addr: dma_addr, bank: dma_bank, din: dma_din};
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner    <= IDLE;
            starve   <= '0;
            phase    <= '0;
            sd_oe    <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= '0;
            sd_bank  <= '0;
            sd_din   <= '0;
            boot_ack <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_wait <= 1'b0;
            dma_dout <= '0;
        end else begin
            boot_ack <= 1'b0;
            dma_ack  <= 1'b0;
            if (phase != PhaseMax) phase <= phase + 4'd1;

            // phase counts cycles since the grant edge; read data is due at its last step.
            if (owner == DMA && sd_oe && phase == LastLat) begin
                dma_ack  <= 1'b1;
                dma_dout <= sd_dout;
            end

            if (ce_ref) begin
                owner    <= grant;
                phase    <= 4'd1;
                sd_oe    <= sel.rd;
                sd_we    <= sel.wr;
                sd_addr  <= sel.addr;
                sd_bank  <= sel.bank;
                sd_din   <= sel.din;
                cpu_wait <= forced && cpu_req;
                boot_ack <= (grant == BOOT);
                if (grant == DMA && dma_we) dma_ack <= 1'b1;
                if (grant == DMA || !dma_req) starve <= '0;
                else if (grant == CPU && !starve_full) starve <= starve + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Self-checking bench for sdram_slot_arbiter: directed slot scenarios plus randomized
// traffic, checked every cycle against a slot-level behavioural model.
module tb_sdram_slot_arbiter;

    localparam int DATA_LAT = 8;
    localparam int MAX_WAIT = 3;
    localparam int SLOT     = 16;
    localparam int W_IDLE = 0, W_BOOT = 1, W_CPU = 2, W_DMA = 3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1, ce_ref = 1'b0;
    logic        boot_mode = 1'b0, boot_wr = 1'b0;
    logic [22:0] boot_addr = '0;
    logic [1:0]  boot_bank = '0;
    logic [7:0]  boot_din = '0;
    logic        boot_ack;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic [1:0]  cpu_bank = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_wait;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [22:0] dma_addr = '0;
    logic [1:0]  dma_bank = '0;
    logic [7:0]  dma_din = '0;
    logic        dma_ack;
    logic [7:0]  dma_dout;
    logic        sd_oe, sd_we;
    logic [22:0] sd_addr;
    logic [1:0]  sd_bank;
    logic [7:0]  sd_din;
    logic [7:0]  sd_dout = '0;

    sdram_slot_arbiter #(.DATA_LAT(DATA_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .boot_mode(boot_mode), .boot_wr(boot_wr), .boot_addr(boot_addr),
        .boot_bank(boot_bank), .boot_din(boot_din), .boot_ack(boot_ack),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank),
        .cpu_din(cpu_din), .cpu_wait(cpu_wait),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_bank(dma_bank),
        .dma_din(dma_din), .dma_ack(dma_ack), .dma_dout(dma_dout),
        .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_bank(sd_bank),
        .sd_din(sd_din), .sd_dout(sd_dout)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;
    int phase    = 0;

    // Model state: expected outputs after the most recent edge.
    logic        m_oe = 0, m_we = 0, m_boot_ack = 0, m_dma_ack = 0, m_cpu_wait = 0;
    logic [22:0] m_addr = '0;
    logic [1:0]  m_bank = '0;
    logic [7:0]  m_din = '0, m_dout = '0;
    int          m_starve = 0;
    int          edge_n = 0;
    int          rd_ack_edge = -1;
    bit          m_ce = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot-level rules: pick an owner at each ce_ref, schedule its acks by cycle number.
    task automatic model_step();
        int  who;
        bit  cpu_req, forced;
        edge_n++;
        m_ce = ce_ref && !reset;
        if (reset) begin
            m_oe = 0; m_we = 0; m_addr = '0; m_bank = '0; m_din = '0;
            m_boot_ack = 0; m_dma_ack = 0; m_cpu_wait = 0; m_dout = '0;
            m_starve = 0; rd_ack_edge = -1;
            return;
        end
        m_boot_ack = 0;
        m_dma_ack  = 0;
        if (edge_n == rd_ack_edge) begin
            m_dma_ack = 1; m_dout = sd_dout; rd_ack_edge = -1;
        end
        if (!ce_ref) return;
        cpu_req = cpu_rd | cpu_wr;
        forced  = !boot_mode && dma_req && (m_starve == MAX_WAIT);
        if (boot_mode)    who = boot_wr ? W_BOOT : W_IDLE;
        else if (forced)  who = W_DMA;
        else if (cpu_req) who = W_CPU;
        else if (dma_req) who = W_DMA;
        else              who = W_IDLE;
        m_cpu_wait = forced && cpu_req;
        case (who)
            W_BOOT: begin
                m_oe = 0; m_we = 1; m_addr = boot_addr; m_bank = boot_bank; m_din = boot_din;
                m_boot_ack = 1;
            end
            W_CPU: begin
                m_oe = cpu_rd; m_we = cpu_wr; m_addr = cpu_addr; m_bank = cpu_bank;
                m_din = cpu_din;
            end
            W_DMA: begin
                m_oe = !dma_we; m_we = dma_we; m_addr = dma_addr; m_bank = dma_bank;
                m_din = dma_din;
                if (dma_we) m_dma_ack = 1;
                else rd_ack_edge = edge_n + DATA_LAT - 1;
            end
            default: begin m_oe = 0; m_we = 0; end
        endcase
        if (who == W_DMA || !dma_req) m_starve = 0;
        else if (who == W_CPU && m_starve < MAX_WAIT) m_starve++;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        checking = 1;
        phase  = (phase + 1) % SLOT;
        ce_ref = (phase == 0);
    endtask

    // Returns one cycle after the edge that sampled ce_ref (slot start + 1).
    task automatic wait_slot_start();
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_ce && guard < 2 * SLOT);
        if (!m_ce) chk("slot_start_timeout", 0, 1);
    endtask

    always @(negedge clk_sys) begin
        if (checking) begin
            chk("sd_oe", sd_oe, m_oe);
            chk("sd_we", sd_we, m_we);
            chk("sd_addr", sd_addr, m_addr);
            chk("sd_bank", sd_bank, m_bank);
            chk("sd_din", sd_din, m_din);
            chk("boot_ack", boot_ack, m_boot_ack);
            chk("dma_ack", dma_ack, m_dma_ack);
            chk("cpu_wait", cpu_wait, m_cpu_wait);
            chk("dma_dout", dma_dout, m_dout);
        end
    end

    initial begin
        int acks;
        // Reset state.
        repeat (3) tick();
        chk("rst_sd_oe", sd_oe, 0);
        chk("rst_sd_we", sd_we, 0);
        chk("rst_sd_addr", sd_addr, 0);
        chk("rst_acks", {boot_ack, dma_ack, cpu_wait}, 0);
        chk("rst_dma_dout", dma_dout, 0);
        reset = 0;

        // Boot write wins even with a CPU read pending.
        boot_mode = 1; boot_wr = 1; boot_addr = 23'h100123; boot_bank = 2'd1;
        boot_din = 8'hA5; cpu_rd = 1; cpu_addr = 23'h000456; cpu_bank = 2'd2;
        wait_slot_start();
        chk("boot_sd_we", sd_we, 1);
        chk("boot_sd_oe", sd_oe, 0);
        chk("boot_sd_addr", sd_addr, 23'h100123);
        chk("boot_sd_din", sd_din, 8'hA5);
        chk("boot_ack_pulse", boot_ack, 1);
        // Loader presents its next byte, then boot_mode falls mid-slot.
        boot_addr = 23'h000777; boot_din = 8'h5A;
        tick();
        chk("boot_ack_end", boot_ack, 0);
        tick(); tick();
        boot_mode = 0;
        tick(); tick();
        chk("boot_slot_held_we", sd_we, 1);
        chk("boot_slot_held_addr", sd_addr, 23'h100123);
        wait_slot_start();
        chk("post_boot_cpu_oe", sd_oe, 1);
        chk("post_boot_cpu_addr", sd_addr, 23'h000456);
        chk("post_boot_no_ack", boot_ack, 0);
        boot_wr = 0;

        // Idle bus: nothing driven, address parked.
        cpu_rd = 0;
        for (int s = 0; s < 4; s++) begin
            wait_slot_start();
            chk("idle_oe_we", {sd_oe, sd_we}, 0);
            chk("idle_addr_hold", sd_addr, 23'h000456);
        end

        // Continuous CPU traffic starves DMA for MAX_WAIT slots, then DMA is forced.
        cpu_rd = 1; cpu_addr = 23'h0000AB; cpu_bank = 2'd0;
        dma_req = 1; dma_we = 0; dma_addr = 23'h007FFF; dma_bank = 2'd3; sd_dout = 8'h3C;
        for (int s = 0; s < 3; s++) begin
            wait_slot_start();
            chk("starve_cpu_addr", sd_addr, 23'h0000AB);
            chk("starve_cpu_wait", cpu_wait, 0);
        end
        wait_slot_start();
        chk("forced_dma_addr", sd_addr, 23'h007FFF);
        chk("forced_dma_bank", sd_bank, 2'd3);
        chk("forced_dma_oe", sd_oe, 1);
        chk("forced_cpu_wait", cpu_wait, 1);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("dma_rd_ack_timing", dma_ack, (k == DATA_LAT) ? 1 : 0);
            if (k == DATA_LAT) begin
                chk("dma_rd_data", dma_dout, 8'h3C);
                dma_req = 0;
            end
        end
        chk("forced_cpu_wait_hold", cpu_wait, 1);
        wait_slot_start();
        chk("cpu_after_force_addr", sd_addr, 23'h0000AB);
        chk("cpu_after_force_wait", cpu_wait, 0);

        // Reset three cycles into a DMA read slot discards the pending ack.
        cpu_rd = 0; dma_req = 1; dma_we = 0; dma_addr = 23'h012345;
        wait_slot_start();
        chk("dma_rd_grant_addr", sd_addr, 23'h012345);
        tick(); tick();
        reset = 1;
        tick();
        chk("midreset_outs", {sd_oe, sd_we, boot_ack, dma_ack, cpu_wait}, 0);
        chk("midreset_addr", sd_addr, 0);
        chk("midreset_dout", dma_dout, 0);
        reset = 0; dma_req = 0;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dma_ack === 1'b1) acks++;
        end
        chk("no_ack_after_reset", acks, 0);

        // Randomized traffic; requesters follow the handshake rules from the model's view.
        for (int c = 0; c < 2500; c++) begin
            tick();
            reset = ($urandom_range(0, 399) == 0);
            sd_dout = 8'($urandom);
            if ($urandom_range(0, 39) == 0) boot_mode = ~boot_mode;
            if (m_boot_ack) boot_wr = 0;
            else if (!boot_wr && $urandom_range(0, 5) == 0) begin
                boot_wr = 1; boot_addr = 23'($urandom); boot_bank = 2'($urandom);
                boot_din = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin cpu_rd = 0; cpu_wr = 0; end
                    1: begin cpu_rd = 1; cpu_wr = 0; end
                    default: begin cpu_rd = 0; cpu_wr = 1; end
                endcase
                cpu_addr = 23'($urandom); cpu_bank = 2'($urandom); cpu_din = 8'($urandom);
            end
            if (m_dma_ack) dma_req = 0;
            else if (!dma_req && $urandom_range(0, 7) == 0) begin
                dma_req = 1; dma_we = 1'($urandom); dma_addr = 23'($urandom);
                dma_bank = 2'($urandom); dma_din = 8'($urandom);
            end
        end
        reset = 0;
        tick(); tick();

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
